// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: fetch/decode bundles, CSR info,
// control word, opcodes and the serialising predicate.
package decode_queue_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  creg_addr_t;
    typedef logic [11:0] csr_addr_t;

    typedef struct packed {
        logic [2:0] alufunc_csr;
        logic       imm_flag;
        logic       wvalid;
        logic       is_mret;
        logic       is_ecall;
        logic       is_exception;
        logic [3:0] exception;
        word_t      mtval;
    } csr_data_t;

    typedef struct packed {
        logic [3:0] alufunc;
        logic       regwrite;
        logic       alusrc_imm;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic       is_csr;
    } ctl_t;

    typedef struct packed {
        word_t     pc;
        word_t     raw_instr;
        logic      en;
        csr_data_t csr_data;
    } fetch_data_t;

    typedef struct packed {
        word_t      pc;
        creg_addr_t ra1;
        creg_addr_t ra2;
        creg_addr_t dst;
        word_t      imm;
        ctl_t       ctl;
        word_t      rd1;
        word_t      rd2;
        word_t      csr_rd;
        csr_data_t  csr_data;
        logic       en;
    } decode_data_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam word_t      INSTR_ECALL = 32'h0000_0073;
    localparam word_t      INSTR_MRET  = 32'h3020_0073;
    localparam logic [3:0] EXC_ILLEGAL = 4'd2;

    function automatic logic is_serial(ctl_t ctl, csr_data_t csr);
        return ctl.is_csr | csr.is_mret | csr.is_ecall | csr.is_exception;
    endfunction

endpackage

// File: rtl/decode_queue_decoder.sv
// Single-instruction RV32I decoder: control word, destination,
// immediate and CSR/exception info.
module decode_queue_decoder
    import decode_queue_pkg::*;
(
    input  word_t      raw_instr,
    output ctl_t       ctl,
    output creg_addr_t dst,
    output word_t      imm,
    output csr_data_t  csr_info
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    creg_addr_t rs1;
    word_t      i_imm, s_imm, b_imm, u_imm, j_imm;

    assign opcode = raw_instr[6:0];
    assign funct3 = raw_instr[14:12];
    assign rs1    = raw_instr[19:15];

    assign i_imm = {{20{raw_instr[31]}}, raw_instr[31:20]};
    assign s_imm = {{20{raw_instr[31]}}, raw_instr[31:25], raw_instr[11:7]};
    assign b_imm = {{19{raw_instr[31]}}, raw_instr[31], raw_instr[7],
                    raw_instr[30:25], raw_instr[11:8], 1'b0};
    assign u_imm = {raw_instr[31:12], 12'd0};
    assign j_imm = {{11{raw_instr[31]}}, raw_instr[31], raw_instr[19:12],
                    raw_instr[20], raw_instr[30:21], 1'b0};

    always_comb begin
        ctl      = '0;
        imm      = '0;
        csr_info = '0;
        unique case (opcode)
            OP_R: begin
                ctl.regwrite = 1'b1;
                ctl.alufunc  = {raw_instr[30], funct3};
            end
            OP_IMM: begin
                ctl.regwrite   = 1'b1;
                ctl.alusrc_imm = 1'b1;
                ctl.alufunc    = {(funct3 == 3'b101) & raw_instr[30], funct3};
                imm            = i_imm;
            end
            OP_LOAD: begin
                ctl.regwrite   = 1'b1;
                ctl.alusrc_imm = 1'b1;
                ctl.memread    = 1'b1;
                imm            = i_imm;
            end
            OP_STORE: begin
                ctl.alusrc_imm = 1'b1;
                ctl.memwrite   = 1'b1;
                imm            = s_imm;
            end
            OP_BRANCH: begin
                ctl.branch  = 1'b1;
                ctl.alufunc = {1'b0, funct3};
                imm         = b_imm;
            end
            OP_LUI, OP_AUIPC: begin
                ctl.regwrite   = 1'b1;
                ctl.alusrc_imm = 1'b1;
                imm            = u_imm;
            end
            OP_JAL: begin
                ctl.regwrite = 1'b1;
                ctl.jump     = 1'b1;
                imm          = j_imm;
            end
            OP_JALR: begin
                ctl.regwrite   = 1'b1;
                ctl.jump       = 1'b1;
                ctl.alusrc_imm = 1'b1;
                imm            = i_imm;
            end
            OP_SYSTEM: begin
                // zimm for csrr*i; zero for ecall/mret
                imm = {27'd0, rs1};
                if (raw_instr == INSTR_ECALL) begin
                    csr_info.is_ecall = 1'b1;
                end else if (raw_instr == INSTR_MRET) begin
                    csr_info.is_mret = 1'b1;
                end else if (funct3[1:0] != 2'b00) begin
                    ctl.regwrite         = 1'b1;
                    ctl.is_csr           = 1'b1;
                    csr_info.alufunc_csr = funct3;
                    csr_info.imm_flag    = funct3[2];
                    csr_info.wvalid      = (funct3[1:0] == 2'b01) || (rs1 != '0);
                end else begin
                    csr_info.is_exception = 1'b1;
                    csr_info.exception    = EXC_ILLEGAL;
                end
            end
            default: begin
                csr_info.is_exception = 1'b1;
                csr_info.exception    = EXC_ILLEGAL;
            end
        endcase
    end

    assign dst = ctl.regwrite ? raw_instr[11:7] : '0;

endmodule

// File: rtl/decode_queue.sv
// DEPTH-entry fetch buffer issuing up to NLANE decoded instructions
// per cycle, with intra-bundle hazard and serialisation checks.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NLANE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  fetch_data_t            in_data,
    output logic [NLANE-1:0]       out_valid,
    input  logic                   out_ready,
    output decode_data_t           dataD  [NLANE],
    output creg_addr_t             ra1    [NLANE],
    output creg_addr_t             ra2    [NLANE],
    input  word_t                  rd1    [NLANE],
    input  word_t                  rd2    [NLANE],
    output csr_addr_t              csr_ra [NLANE],
    input  word_t                  csr_rd [NLANE],
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_data_t   mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          wr;
    logic [1:0]    npop;

    fetch_data_t      ent [NLANE];
    ctl_t             ctl [NLANE];
    creg_addr_t       dst [NLANE];
    word_t            imm [NLANE];
    csr_data_t        dec_csr [NLANE];
    logic [NLANE-1:0] serial;

    assign in_ready = (count != CW'(DEPTH));
    assign wr       = in_valid && in_ready && !flush && in_data.en;

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        csr_data_t merged;
        logic      en_unused;

        assign ent[i]    = mem[rptr + PW'(i)];
        assign en_unused = ent[i].en;

        decode_queue_decoder u_dec (
            .raw_instr (ent[i].raw_instr),
            .ctl       (ctl[i]),
            .dst       (dst[i]),
            .imm       (imm[i]),
            .csr_info  (dec_csr[i])
        );

        // a fetch-side exception keeps its own cause and info
        always_comb begin
            merged       = dec_csr[i];
            merged.mtval = ent[i].csr_data.mtval;
            if (ent[i].csr_data.is_exception)
                merged = ent[i].csr_data;
        end

        assign serial[i] = is_serial(ctl[i], merged);
        assign ra1[i]    = ent[i].raw_instr[19:15];
        assign ra2[i]    = ent[i].raw_instr[24:20];
        assign csr_ra[i] = ent[i].raw_instr[31:20];

        assign dataD[i] = '{
            pc:       ent[i].pc,
            ra1:      ent[i].raw_instr[19:15],
            ra2:      ent[i].raw_instr[24:20],
            dst:      dst[i],
            imm:      imm[i],
            ctl:      ctl[i],
            rd1:      rd1[i],
            rd2:      rd2[i],
            csr_rd:   csr_rd[i],
            csr_data: out_valid[i] ? merged : ent[i].csr_data,
            en:       out_valid[i]
        };
    end

    assign out_valid[0] = (count != '0);

    if (NLANE == 2) begin : g_dual
        logic hazard;
        assign hazard = ctl[0].regwrite && (dst[0] != '0) &&
                        ((ent[1].raw_instr[19:15] == dst[0]) ||
                         (ent[1].raw_instr[24:20] == dst[0]));
        assign out_valid[1] = (count >= CW'(2)) && !serial[0] &&
                              !serial[1] && !hazard;
    end

    always_comb begin
        npop = '0;
        for (int i = 0; i < NLANE; i++)
            npop = npop + 2'(out_valid[i]);
        if (!out_ready)
            npop = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else if (flush) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (wr)
                wptr <= wptr + PW'(1);
            rptr  <= rptr + PW'(npop);
            count <= count + CW'(wr) - CW'(npop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr] <= in_data;
    end

endmodule
